// File: rtl/fifo_uart_pkg.sv
// Shared types and sizing helpers for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

   // Fixed encoding keeps state values stable for debug probes and waveforms.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5
   } tx_state_e;

   localparam int DEF_CLKS_PER_BIT = 4;

   // Baud counter width; never narrower than one bit.
   function automatic int baud_cnt_w(input int clks_per_bit);
      return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
   endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial-side status, bundled between the drain stage and its surroundings.
interface fifo_uart_tx_if #(
   parameter int DATA_W = 8
);
   logic              i_enable;
   logic              i_fifo_empty;
   logic [DATA_W-1:0] i_fifo_rd_data;
   logic              o_fifo_rd_en;
   logic              o_tx;
   logic              o_busy;
   logic              o_done;

   modport master (
      output i_enable, i_fifo_empty, i_fifo_rd_data,
      input  o_fifo_rd_en, o_tx, o_busy, o_done
   );

   modport slave (
      input  i_enable, i_fifo_empty, i_fifo_rd_data,
      output o_fifo_rd_en, o_tx, o_busy, o_done
   );
endinterface

// File: rtl/uart_baud_cnt.sv
// Per-bit cycle counter: held at 0 while cleared, otherwise counts 0..CLKS_PER_BIT-1
// and wraps; o_tick marks the last cycle of the current bit.
module uart_baud_cnt
   import fifo_uart_pkg::*;
#(
   parameter  int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   localparam int CNT_W        = baud_cnt_w(CLKS_PER_BIT)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   // Next count: clear wins, then wrap at the last cycle of a bit.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (i_clr || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   // Count register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt  = cnt_q;
   assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a registered-read FIFO one byte at a time and serialises each byte as
// a UART frame: start bit, data LSB first, optional even parity, stop bit.
//
// state  | meaning
// IDLE   | line high; pop when enabled and FIFO not empty
// LOAD   | popped byte valid on the read port; capture it and its parity
// START  | start bit (0)
// DATA   | data bits, LSB first, one per bit period
// PARITY | even-parity bit (only when PARITY_EN)
// STOP   | stop bit (1); done pulses in its last cycle
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DATA_W       = 8,
   parameter int PARITY_EN    = 0
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   fifo_uart_tx_if.slave  bus
);

   localparam int               CNT_W    = baud_cnt_w(CLKS_PER_BIT);
   localparam int               BIT_W    = (DATA_W <= 2) ? 1 : $clog2(DATA_W);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
   // Count value one cycle before the end of a bit; done is registered, so it
   // is launched here to be visible during the final stop cycle.
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

   tx_state_e         state_d, state_q;
   logic [DATA_W-1:0] shift_d, shift_q;
   logic [BIT_W-1:0]  bit_cnt_d, bit_cnt_q;
   logic              parity_d, parity_q;
   logic              tx_d, tx_q;
   logic              done_d, done_q;
   logic              busy_d, busy_q;

   logic              baud_clr;
   logic              baud_tick;
   logic [CNT_W-1:0]  baud_cnt;
   logic              rd_en;

   // The counter restarts each frame from LOAD so START gets a full bit period.
   assign baud_clr = (state_q == ST_IDLE) || (state_q == ST_LOAD);

   uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (baud_clr),
      .o_cnt   (baud_cnt),
      .o_tick  (baud_tick)
   );

   // Pop request; gated by reset so an un-reset FIFO is never drained while we are held.
   assign rd_en = i_rst_n && (state_q == ST_IDLE) && bus.i_enable && !bus.i_fifo_empty;

   // Next-state, datapath and registered-output values for the frame sequencer.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      parity_d  = parity_q;
      tx_d      = tx_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (rd_en) begin
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            shift_d   = bus.i_fifo_rd_data;
            parity_d  = ^bus.i_fifo_rd_data;
            bit_cnt_d = '0;
            tx_d      = 1'b0;
            state_d   = ST_START;
         end

         ST_START: begin
            if (baud_tick) begin
               tx_d    = shift_q[0];
               state_d = ST_DATA;
            end
         end

         ST_DATA: begin
            if (baud_tick) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
                  if (PARITY_EN != 0) begin
                     tx_d    = parity_q;
                     state_d = ST_PARITY;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = ST_STOP;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  tx_d      = shift_q[1];
               end
            end
         end

         ST_PARITY: begin
            if (baud_tick) begin
               tx_d    = 1'b1;
               state_d = ST_STOP;
            end
         end

         ST_STOP: begin
            if (baud_cnt == PRE_LAST) begin
               done_d = 1'b1;
            end
            if (baud_tick) begin
               tx_d    = 1'b1;
               state_d = ST_IDLE;
            end
         end

         default: begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State, datapath and output registers; reset forces an idle, high line immediately.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         parity_q  <= 1'b0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         parity_q  <= parity_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.o_fifo_rd_en = rd_en;
   assign bus.o_tx         = tx_q;
   assign bus.o_busy       = busy_q;
   assign bus.o_done       = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO feeds two instances (no parity and
// even parity); expected frames are built from each byte's bit pattern.
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en0 = 1'b0;
   logic       en1 = 1'b0;
   logic       sel = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_rd_data = 8'h00;
   logic [7:0] fq[$];
   logic [7:0] exp_q[$];
   int         cyc = 0;
   int         underflow = 0;
   int         passed = 0;
   int         total = 0;

   fifo_uart_tx_if #(.DATA_W(8)) bus0 ();
   fifo_uart_tx_if #(.DATA_W(8)) bus1 ();

   assign bus0.i_enable       = en0;
   assign bus0.i_fifo_empty   = fifo_empty;
   assign bus0.i_fifo_rd_data = fifo_rd_data;
   assign bus1.i_enable       = en1;
   assign bus1.i_fifo_empty   = fifo_empty;
   assign bus1.i_fifo_rd_data = fifo_rd_data;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(0)) dut0 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus0)
   );

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1)) dut1 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus1)
   );

   logic tx_s, busy_s, done_s, rd_s, rd_any;
   assign tx_s   = sel ? bus1.o_tx         : bus0.o_tx;
   assign busy_s = sel ? bus1.o_busy       : bus0.o_busy;
   assign done_s = sel ? bus1.o_done       : bus0.o_done;
   assign rd_s   = sel ? bus1.o_fifo_rd_en : bus0.o_fifo_rd_en;
   assign rd_any = bus0.o_fifo_rd_en | bus1.o_fifo_rd_en;

   always #5 clk = ~clk;

   // 16-deep FIFO with registered read data and registered empty flag.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd_any && fifo_empty) underflow <= underflow + 1;
      if (rd_any && fq.size() != 0) fifo_rd_data <= fq.pop_front();
      if (wr_en && fq.size() < 16) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic push(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      exp_q.push_back(b);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Wait (bounded) for a pop request; caller sits at a falling edge.
   task automatic wait_pop(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (rd_s) begin
            ok = 1'b1;
            check("busy_at_pop", 32'(busy_s), 32'd0);
            return;
         end
         @(negedge clk);
      end
      check("pop_timeout", 32'd0, 32'd1);
   endtask

   // Check one whole frame cycle by cycle against the next expected byte.
   task automatic expect_frame(input int drop_at, output int pop_at);
      bit         ok;
      logic [7:0] b;
      logic [7:0] got;
      logic       eb;
      int         flen, idx;
      pop_at = -1;
      got    = 8'h00;
      wait_pop(ok);
      if (!ok) return;
      pop_at = cyc;
      if (exp_q.size() == 0) begin
         check("exp_queue_empty", 32'd0, 32'd1);
         return;
      end
      b    = exp_q.pop_front();
      flen = (sel ? 11 : 10) * CPB;
      for (int k = 1; k <= flen + 1; k++) begin
         @(negedge clk);
         #1;
         if (k == drop_at) en0 = 1'b0;
         idx = (k - 2) / CPB;
         if (k == 1)                 eb = 1'b1;
         else if (idx == 0)          eb = 1'b0;
         else if (idx <= 8)          eb = b[idx-1];
         else if (idx == 9 && sel)   eb = 1'($countones(b) % 2);
         else                        eb = 1'b1;
         check($sformatf("tx k=%0d", k), 32'(tx_s), 32'(eb));
         check($sformatf("done k=%0d", k), 32'(done_s), 32'(k == flen + 1));
         check($sformatf("busy k=%0d", k), 32'(busy_s), 32'd1);
         if (rd_s) check("rd_en_mid_frame", 32'(rd_s), 32'd0);
         if (k >= 2 && idx >= 1 && idx <= 8 && ((k - 2) % CPB) == CPB / 2) got[idx-1] = tx_s;
      end
      check("byte", 32'(got), 32'(b));
   endtask

   task automatic hold_idle(input string tag, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         if (rd_s || busy_s || !tx_s || done_s) bad++;
      end
      check(tag, 32'(bad), 32'd0);
   endtask

   initial begin
      int p1, p2, p3, pd;
      bit ok;

      // 1: reset and idle with empty FIFO and enable high
      en0 = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_tx", 32'(bus0.o_tx), 32'd1);
      check("rst_busy", 32'(bus0.o_busy), 32'd0);
      check("rst_done", 32'(bus0.o_done), 32'd0);
      check("rst_rd_en", 32'(bus0.o_fifo_rd_en), 32'd0);
      rst_n = 1'b1;
      hold_idle("idle_empty_50", 50);

      // 2: single byte 0xA5 with enable held
      push(8'hA5);
      expect_frame(-1, p1);
      @(negedge clk);
      hold_idle("idle_after_a5", 10);

      // 3: three back-to-back frames
      en0 = 1'b0;
      push(8'h01); push(8'h80); push(8'hFF);
      en0 = 1'b1;
      expect_frame(-1, p1);
      expect_frame(-1, p2);
      expect_frame(-1, p3);
      check("gap_1_2", 32'(p2 - p1), 32'(10 * CPB + 2));
      check("gap_2_3", 32'(p3 - p2), 32'(10 * CPB + 2));
      @(negedge clk);
      #1;
      check("empty_after_3", 32'(fifo_empty), 32'd1);

      // enable dropped mid-frame: frame completes, next byte waits
      en0 = 1'b0;
      push(8'h3C); push(8'hC3);
      en0 = 1'b1;
      expect_frame(10, p1);
      hold_idle("hold_after_disable", 60);
      en0 = 1'b1;
      expect_frame(-1, p1);

      // 4: fill all 16 entries with random bytes, then drain
      en0 = 1'b0;
      for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)));
      en0 = 1'b1;
      for (int i = 0; i < 16; i++) expect_frame(-1, p1);
      @(negedge clk);
      #1;
      check("empty_after_16", 32'(fifo_empty), 32'd1);
      check("no_underflow", 32'(underflow), 32'd0);

      // 5: reset during data bit 3 of 0x5A; popped byte is lost
      en0 = 1'b0;
      push(8'h5A); push(8'h96);
      en0 = 1'b1;
      wait_pop(ok);
      if (ok) void'(exp_q.pop_front());
      for (int k = 1; k <= 19; k++) @(negedge clk);
      #1;
      check("pre_rst_busy", 32'(bus0.o_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_tx", 32'(bus0.o_tx), 32'd1);
      check("midrst_busy", 32'(bus0.o_busy), 32'd0);
      check("midrst_rd_en", 32'(bus0.o_fifo_rd_en), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      expect_frame(-1, p1);

      // 6: even parity instance
      en0 = 1'b0;
      sel = 1'b1;
      @(negedge clk);
      push(8'h07); push(8'h03); push(8'($urandom_range(0, 255)));
      en1 = 1'b1;
      expect_frame(-1, p1);
      expect_frame(-1, p2);
      expect_frame(-1, p3);
      pd = p2 - p1;
      check("par_gap", 32'(pd), 32'(11 * CPB + 2));
      @(negedge clk);
      #1;
      check("par_idle_busy", 32'(busy_s), 32'd0);
      check("final_underflow", 32'(underflow), 32'd0);
      check("final_empty", 32'(fifo_empty), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
